flash_read_arbiter: RTL

- Shares the single SPI flash read engine between two 16-bit word requesters.
- Requester 0 is the CPU instruction fetch port; requester 1 is the loader/debug data port.
- Arbitrates between them round-robin, sequences one flash word read per grant, and returns the data on a per-port response strobe.
- Adds a flash base offset and a watchdog timeout so a hung transfer cannot deadlock either requester.

---
 rtl/flash_read_arbiter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/flash_read_arbiter.sv
// flash_read_arbiter
//
// Shares one SPI flash word-read engine between two 16-bit requesters:
// port 0 (CPU instruction fetch) and port 1 (loader/debug data). Requests are
// arbitrated round-robin. Each grant runs one flash read. The result returns on
// a per-port one-cycle strobe. A watchdog aborts a read that never completes.
//
// Ports:
//   clk, reset               system clock, asynchronous active-high reset
//   reqN_valid/addr/ready    request handshake, word address (N = 0, 1)
//   respN_valid              one-cycle response strobe for port N
//   resp_data, resp_err      shared response word; err flags a timed-out read
//   flash_reset              holds the engine idle while high
//   flash_addr               byte address presented to the engine
//   flash_ready, flash_rdata engine done pulse and its data
//   busy                     high whenever a transfer is in progress

module flash_read_arbiter #(
  parameter logic [23:0] BASE_ADDR = 24'h100000,
  parameter int unsigned TIMEOUT   = 1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [14:0] req0_addr,
  output logic        req0_ready,
  output logic        resp0_valid,
  input  logic        req1_valid,
  input  logic [14:0] req1_addr,
  output logic        req1_ready,
  output logic        resp1_valid,
  output logic [15:0] resp_data,
  output logic        resp_err,
  output logic        flash_reset,
  output logic [23:0] flash_addr,
  input  logic        flash_ready,
  input  logic [15:0] flash_rdata,
  output logic        busy
);

  // The counter never needs to exceed TIMEOUT-1: RUN is left on that value.
  localparam int unsigned    CntW    = $clog2(TIMEOUT);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StRun, StGap} state_e;

  state_e            state_q, state_d;
  logic              grant_q, grant_d;
  logic              last_grant_q, last_grant_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [23:0]       addr_q, addr_d;
  logic              frst_q, frst_d;
  logic [15:0]       data_q, data_d;
  logic              err_q, err_d;
  logic              v0_q, v0_d;
  logic              v1_q, v1_d;
  logic              acc0, acc1;
  logic [14:0]       sel_addr;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    frst_d       = frst_q;
    data_d       = data_q;
    err_d        = err_q;
    v0_d         = 1'b0;
    v1_d         = 1'b0;
    acc0         = 1'b0;
    acc1         = 1'b0;
    sel_addr     = req0_addr;

    unique case (state_q)
      StIdle: begin
        // On a tie the port that did not win last time gets the grant.
        acc0 = req0_valid && (!req1_valid || last_grant_q);
        acc1 = req1_valid && (!req0_valid || !last_grant_q);
        if (acc1) begin
          sel_addr = req1_addr;
        end
        if (acc0 || acc1) begin
          grant_d      = acc1;
          last_grant_d = acc1;
          // Word to byte address; the 24-bit sum wraps on overflow.
          addr_d       = BASE_ADDR + {8'd0, sel_addr, 1'b0};
          frst_d       = 1'b0;
          cnt_d        = '0;
          state_d      = StRun;
        end
      end
      StRun: begin
        cnt_d = cnt_q + CntW'(1);
        // A done pulse on the timeout cycle still returns real data.
        if (flash_ready || (cnt_q == CntLast)) begin
          data_d  = flash_ready ? flash_rdata : 16'hFFFF;
          err_d   = !flash_ready;
          v0_d    = !grant_q;
          v1_d    = grant_q;
          frst_d  = 1'b1;
          state_d = StGap;
        end
      end
      StGap: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      addr_q       <= BASE_ADDR;
      frst_q       <= 1'b1;
      data_q       <= 16'h0000;
      err_q        <= 1'b0;
      v0_q         <= 1'b0;
      v1_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      frst_q       <= frst_d;
      data_q       <= data_d;
      err_q        <= err_d;
      v0_q         <= v0_d;
      v1_q         <= v1_d;
    end
  end

  assign req0_ready  = acc0;
  assign req1_ready  = acc1;
  assign resp0_valid = v0_q;
  assign resp1_valid = v1_q;
  assign resp_data   = data_q;
  assign resp_err    = err_q;
  assign flash_reset = frst_q;
  assign flash_addr  = addr_q;
  assign busy        = (state_q != StIdle);

endmodule
